// File: rtl/rsa_regbank_if.sv
// Register-bus interface between the SPI slave (master side) and rsa_regbank (slave side).
//   reg_addr  : register address
//   reg_wdata : write data
//   reg_wr    : one-cycle write strobe
//   reg_rdata : combinational read data for reg_addr
interface rsa_regbank_if #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned REG_W  = 8
);
   logic [ADDR_W-1:0] reg_addr;
   logic [REG_W-1:0]  reg_wdata;
   logic              reg_wr;
   logic [REG_W-1:0]  reg_rdata;

   modport master (output reg_addr, output reg_wdata, output reg_wr, input reg_rdata);
   modport slave  (input reg_addr, input reg_wdata, input reg_wr, output reg_rdata);
endinterface

// File: rtl/rsa_regbank.sv
// Register bank fronting an RSA core: operand registers, result capture,
// start/stop command pulses and busy/done/err status.
//   clk, rst          : clock, asynchronous active-high reset
//   ena               : global enable; low holds all state and suppresses pulses
//   bus (slave)       : reg_addr / reg_wdata / reg_wr in, reg_rdata out
//   rsa_p/e/m/const   : operands to the RSA core
//   rsa_c, eoc        : result and end-of-computation from the RSA core
//   start_cmd/stop_cmd: single-cycle command pulses
//   spare             : spare register contents
module rsa_regbank #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned REG_W  = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   rsa_regbank_if.slave      bus,
   output logic [WIDTH-1:0]  rsa_p,
   output logic [WIDTH-1:0]  rsa_e,
   output logic [WIDTH-1:0]  rsa_m,
   output logic [WIDTH-1:0]  rsa_const,
   input  logic [WIDTH-1:0]  rsa_c,
   input  logic              eoc,
   output logic              start_cmd,
   output logic              stop_cmd,
   output logic [REG_W-1:0]  spare
);

   localparam int unsigned NB      = WIDTH / REG_W;
   localparam int unsigned N_RW    = 4;
   localparam int unsigned OP_BASE = 4;
   localparam int unsigned A_STAT  = 0;
   localparam int unsigned A_CTRL  = 1;
   localparam int unsigned A_SPARE = 2;

   logic [WIDTH-1:0] opr_q [N_RW];
   logic [WIDTH-1:0] opr_d [N_RW];
   logic [WIDTH-1:0] c_q, c_d;
   logic [REG_W-1:0] spare_q, spare_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             start_cmd_q, start_cmd_d;
   logic             stop_cmd_q, stop_cmd_d;

   logic wr_en, ctrl_wr, start_req, stop_req, clr_req;
   logic start_ok, start_err, eoc_cap, op_hit, op_err;

   // Write/command decode; every decision uses busy as registered this cycle.
   always_comb begin
      wr_en     = bus.reg_wr & ena;
      ctrl_wr   = wr_en && (bus.reg_addr == ADDR_W'(A_CTRL));
      start_req = ctrl_wr & bus.reg_wdata[0];
      stop_req  = ctrl_wr & bus.reg_wdata[1];
      clr_req   = ctrl_wr & bus.reg_wdata[2];
      eoc_cap   = ena & eoc & busy_q;
      // stop overrides start entirely, including the busy-start error
      start_ok  = start_req & ~stop_req & ~busy_q;
      start_err = start_req & ~stop_req & busy_q;
      op_hit    = 1'b0;
      for (int unsigned i = 0; i < N_RW * NB; i++) begin
         if (bus.reg_addr == ADDR_W'(OP_BASE + i)) op_hit = 1'b1;
      end
      op_err    = wr_en & op_hit & busy_q;
   end

   // Next-state computation.
   always_comb begin
      busy_d = busy_q;
      if (eoc_cap)  busy_d = 1'b0;
      if (start_ok) busy_d = 1'b1;
      if (stop_req) busy_d = 1'b0;

      // clear first so a coincident set wins
      done_d = done_q;
      if (clr_req) done_d = 1'b0;
      if (eoc_cap) done_d = 1'b1;

      err_d = err_q;
      if (clr_req)             err_d = 1'b0;
      if (start_err || op_err) err_d = 1'b1;

      opr_d = opr_q;
      for (int unsigned o = 0; o < N_RW; o++) begin
         for (int unsigned k = 0; k < NB; k++) begin
            if (wr_en && !busy_q && bus.reg_addr == ADDR_W'(OP_BASE + o * NB + k))
               opr_d[o][k*REG_W +: REG_W] = bus.reg_wdata;
         end
      end

      c_d         = eoc_cap ? rsa_c : c_q;
      spare_d     = (wr_en && bus.reg_addr == ADDR_W'(A_SPARE)) ? bus.reg_wdata : spare_q;
      start_cmd_d = start_ok;
      stop_cmd_d  = stop_req;
   end

   // Read mux; unmapped, write-only and reserved addresses read 0.
   always_comb begin
      bus.reg_rdata = '0;
      if (bus.reg_addr == ADDR_W'(A_STAT))  bus.reg_rdata = REG_W'({err_q, done_q, busy_q});
      if (bus.reg_addr == ADDR_W'(A_SPARE)) bus.reg_rdata = spare_q;
      for (int unsigned o = 0; o <= N_RW; o++) begin
         for (int unsigned k = 0; k < NB; k++) begin
            if (bus.reg_addr == ADDR_W'(OP_BASE + o * NB + k))
               bus.reg_rdata = (o == N_RW) ? c_q[k*REG_W +: REG_W] : opr_q[o][k*REG_W +: REG_W];
         end
      end
   end

   // State registers; ena gates every state change through the decode above.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opr_q       <= '{default: '0};
         c_q         <= '0;
         spare_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         start_cmd_q <= 1'b0;
         stop_cmd_q  <= 1'b0;
      end else begin
         opr_q       <= opr_d;
         c_q         <= c_d;
         spare_q     <= spare_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         start_cmd_q <= start_cmd_d;
         stop_cmd_q  <= stop_cmd_d;
      end
   end

   assign rsa_p     = opr_q[0];
   assign rsa_e     = opr_q[1];
   assign rsa_m     = opr_q[2];
   assign rsa_const = opr_q[3];
   assign spare     = spare_q;
   assign start_cmd = start_cmd_q;
   assign stop_cmd  = stop_cmd_q;

endmodule

// File: tb/tb_rsa_regbank.sv
// Bench for rsa_regbank: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural register model.
module tb_rsa_regbank;

   localparam int unsigned WIDTH  = 16;
   localparam int unsigned REG_W  = 8;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned NB     = WIDTH / REG_W;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             ena = 1'b1;
   logic [WIDTH-1:0] rsa_p, rsa_e, rsa_m, rsa_const;
   logic [WIDTH-1:0] rsa_c = '0;
   logic             eoc = 1'b0;
   logic             start_cmd, stop_cmd;
   logic [REG_W-1:0] spare;

   rsa_regbank_if #(.ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

   rsa_regbank #(.WIDTH(WIDTH), .REG_W(REG_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .ena(ena), .bus(bus),
      .rsa_p(rsa_p), .rsa_e(rsa_e), .rsa_m(rsa_m), .rsa_const(rsa_const),
      .rsa_c(rsa_c), .eoc(eoc), .start_cmd(start_cmd), .stop_cmd(stop_cmd),
      .spare(spare)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: operands as whole numbers, index 0..3 = P/E/M/CONST, 4 = C.
   logic [63:0] m_op [5] = '{default: '0};
   logic [7:0]  m_spare = '0;
   bit          m_busy = 0, m_done = 0, m_err = 0, m_start = 0, m_stop = 0;

   function automatic logic [7:0] m_read(input int unsigned a);
      int unsigned o, k;
      if (a == 0) return {5'b0, m_err, m_done, m_busy};
      if (a == 2) return m_spare;
      if (a >= 4 && a < 4 + 5 * NB) begin
         o = (a - 4) / NB;
         k = (a - 4) % NB;
         return 8'(m_op[o] >> (8 * k));
      end
      return 8'h00;
   endfunction

   always @(posedge clk or posedge rst) begin : model
      int unsigned a;
      bit st, sp, cl, b0, set_err, set_done;
      if (rst) begin
         m_op = '{default: '0};
         m_spare = '0;
         m_busy = 0; m_done = 0; m_err = 0; m_start = 0; m_stop = 0;
      end else begin
         m_start = 0;
         m_stop  = 0;
         if (ena) begin
            a  = int'(bus.reg_addr);
            b0 = m_busy;
            st = bus.reg_wr && a == 1 && bus.reg_wdata[0];
            sp = bus.reg_wr && a == 1 && bus.reg_wdata[1];
            cl = bus.reg_wr && a == 1 && bus.reg_wdata[2];
            set_done = eoc && b0;
            set_err  = 0;
            if (set_done) m_op[4] = 64'(rsa_c);
            if (sp) begin
               m_busy = 0;
               m_stop = 1;
            end else if (st && b0) begin
               set_err = 1;
               if (set_done) m_busy = 0;
            end else if (st) begin
               m_busy  = 1;
               m_start = 1;
            end else if (set_done) begin
               m_busy = 0;
            end
            if (bus.reg_wr && a >= 4 && a < 4 + 4 * NB) begin
               if (b0) set_err = 1;
               else begin
                  m_op[(a - 4) / NB][8 * ((a - 4) % NB) +: 8] = bus.reg_wdata;
                  m_op[(a - 4) / NB] &= 64'((65'd1 << WIDTH) - 1);
               end
            end
            if (bus.reg_wr && a == 2) m_spare = bus.reg_wdata;
            if (cl) begin m_done = 0; m_err = 0; end
            if (set_done) m_done = 1;
            if (set_err)  m_err  = 1;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("rdata",     64'(bus.reg_rdata), 64'(m_read(int'(bus.reg_addr))));
      chk("rsa_p",     64'(rsa_p),     m_op[0]);
      chk("rsa_e",     64'(rsa_e),     m_op[1]);
      chk("rsa_m",     64'(rsa_m),     m_op[2]);
      chk("rsa_const", 64'(rsa_const), m_op[3]);
      chk("start_cmd", 64'(start_cmd), 64'(m_start));
      chk("stop_cmd",  64'(stop_cmd),  64'(m_stop));
      chk("spare",     64'(spare),     64'(m_spare));
   end

   task automatic wr(input int unsigned a, input logic [7:0] d);
      @(posedge clk); #1;
      bus.reg_addr  = ADDR_W'(a);
      bus.reg_wdata = d;
      bus.reg_wr    = 1'b1;
      @(posedge clk); #1;
      bus.reg_wr    = 1'b0;
   endtask

   task automatic rd(input int unsigned a, output logic [7:0] v);
      bus.reg_addr = ADDR_W'(a);
      @(negedge clk);
      v = bus.reg_rdata;
   endtask

   initial begin
      logic [7:0] v;
      bus.reg_addr = '0; bus.reg_wdata = '0; bus.reg_wr = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      rd(0, v); chk("lit_status_reset", 64'(v), 64'h00);
      chk("lit_rsa_p_reset", 64'(rsa_p), 64'h0);

      // operand write/readback and reserved address
      wr(4, 8'h34); wr(5, 8'h12); wr(2, 8'h5A);
      @(negedge clk); chk("lit_rsa_p", 64'(rsa_p), 64'h1234);
      rd(4, v); chk("lit_p_b0", 64'(v), 64'h34);
      rd(5, v); chk("lit_p_b1", 64'(v), 64'h12);
      rd(3, v); chk("lit_reserved", 64'(v), 64'h00);
      rd(2, v); chk("lit_spare", 64'(v), 64'h5A);

      // start pulse, busy write rejected
      wr(1, 8'h01);
      rd(0, v); chk("lit_status_busy", 64'(v), 64'h01);
      chk("lit_start_pulse", 64'(start_cmd), 64'h1);
      @(negedge clk); chk("lit_start_gone", 64'(start_cmd), 64'h0);
      wr(4, 8'hFF);
      @(negedge clk); chk("lit_rsa_p_hold", 64'(rsa_p), 64'h1234);
      rd(0, v); chk("lit_status_err", 64'(v), 64'h05);

      // held eoc captures once
      wr(1, 8'h04);
      @(posedge clk); #1; rsa_c = 16'hBEEF; eoc = 1'b1;
      repeat (3) @(posedge clk);
      #1 eoc = 1'b0;
      rd(12, v); chk("lit_c_b0", 64'(v), 64'hEF);
      rd(13, v); chk("lit_c_b1", 64'(v), 64'hBE);
      rd(0, v);  chk("lit_status_done", 64'(v), 64'h02);
      rsa_c = 16'h1111;
      repeat (2) @(posedge clk);
      rd(12, v); chk("lit_c_hold", 64'(v), 64'hEF);

      // stop beats start; clear_flags
      wr(1, 8'h05);
      wr(1, 8'h03);
      rd(0, v); chk("lit_status_stop", 64'(v), 64'h00);
      chk("lit_stop_pulse", 64'(stop_cmd), 64'h1);
      chk("lit_no_start", 64'(start_cmd), 64'h0);
      wr(1, 8'h01); wr(1, 8'h01);
      rd(0, v); chk("lit_status_err2", 64'(v), 64'h05);
      wr(1, 8'h04);
      rd(0, v); chk("lit_status_clr", 64'(v), 64'h01);

      // ena low suppresses writes and pulses
      wr(1, 8'h02);
      ena = 1'b0;
      wr(1, 8'h01);
      rd(0, v); chk("lit_status_ena", 64'(v), 64'h00);
      chk("lit_ena_no_pulse", 64'(start_cmd), 64'h0);
      ena = 1'b1;

      // asynchronous reset while busy
      wr(1, 8'h01);
      bus.reg_addr = ADDR_W'(0);
      #1 rst = 1'b1;
      #1;
      chk("lit_rst_start", 64'(start_cmd), 64'h0);
      chk("lit_rst_rsa_p", 64'(rsa_p), 64'h0);
      chk("lit_rst_spare", 64'(spare), 64'h0);
      chk("lit_rst_status", 64'(bus.reg_rdata), 64'h0);
      @(posedge clk); #1 rst = 1'b0;
      rd(12, v); chk("lit_rst_c", 64'(v), 64'h00);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         rst = ($urandom_range(0, 399) == 0);
         ena = ($urandom_range(0, 9) != 0);
         bus.reg_wr = ($urandom_range(0, 9) < 4);
         bus.reg_addr = ($urandom_range(0, 3) == 0) ? ADDR_W'(1) : ADDR_W'($urandom_range(0, 15));
         bus.reg_wdata = 8'($urandom);
         if (bus.reg_addr == ADDR_W'(1) && $urandom_range(0, 3) != 0)
            bus.reg_wdata = 8'($urandom_range(0, 7));
         eoc = ($urandom_range(0, 6) == 0);
         if ($urandom_range(0, 3) == 0) rsa_c = 16'($urandom);
      end
      @(posedge clk); #1;
      rst = 1'b0; bus.reg_wr = 1'b0; eoc = 1'b0;
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rsa_regbank.md
RSA_REGBANK -- requirements
Module: rsa_regbank

Interface
REQ-001 SHALL have parameter WIDTH, default 16: RSA operand width in bits, a multiple of REG_W, range REG_W..64.
REQ-002 SHALL have parameter REG_W, default 8: register-bus data width.
REQ-003 SHALL have parameter ADDR_W, default 4: register address width; 4+5*(WIDTH/REG_W) <= 2**ADDR_W; NB = WIDTH/REG_W.
REQ-004 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1: one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port ena, input, 1: when low, all state holds and command pulses are 0.
REQ-007 SHALL have port reg_addr, input, ADDR_W: register address from SPI slave.
REQ-008 SHALL have port reg_wdata, input, REG_W: write data.
REQ-009 SHALL have port reg_wr, input, 1: one-cycle write strobe.
REQ-010 SHALL have port reg_rdata, output, REG_W: combinational read data for reg_addr.
REQ-011 SHALL have ports rsa_p, rsa_e, rsa_m, rsa_const, output, WIDTH each: operands to the RSA core.
REQ-012 SHALL have port rsa_c, input, WIDTH: result from the RSA core.
REQ-013 SHALL have port eoc, input, 1: end-of-computation, level or pulse.
REQ-014 SHALL have ports start_cmd and stop_cmd, output, 1 each: single-cycle command pulses.
REQ-015 SHALL have port spare, output, REG_W: spare register contents.

Function
REQ-016 SHALL decode the address map as follows: 0 = STATUS (RO; bit0 busy, bit1 done, bit2 err, others 0); 1 = CTRL (WO; bit0 start, bit1 stop, bit2 clear_flags; reads 0); 2 = SPARE (RW); 3 = reserved, reads 0.
REQ-017 SHALL map operand o (P=0, E=1, M=2, CONST=3, C=4) byte k at address 4+o*NB+k, little-endian (k=0 = bits REG_W-1:0); all other addresses read 0 and ignore writes.
REQ-018 SHALL make P/E/M/CONST RW, driving rsa_p/e/m/const directly from their byte registers.
REQ-019 SHALL make C RO; writes to C are silently ignored.
REQ-020 SHALL qualify every write with reg_wr=1 and ena=1; writes take effect on the same clock edge.
REQ-021 SHALL evaluate all decisions against busy as registered at the start of the cycle.
REQ-022 On CTRL write with start=1 and busy=0, SHALL set busy and assert start_cmd for exactly the next cycle.
REQ-023 On CTRL write with start=1 and busy=1, SHALL issue no pulse and set err.
REQ-024 On CTRL write with stop=1, SHALL clear busy and pulse stop_cmd next cycle, with C unchanged; if start=1 and stop=1 together, stop wins and err is unaffected.
REQ-025 While busy=1, SHALL ignore writes to P/E/M/CONST and set err.
REQ-026 On eoc=1 and busy=1, SHALL load C from rsa_c, clear busy, and set done; eoc with busy=0 SHALL be ignored, so a held eoc captures once.
REQ-027 SHALL make done and err sticky until a CTRL write with clear_flags=1; a set and a clear in the same cycle leaves the flag set.
REQ-028 On eoc coinciding with a CTRL start write while busy=1, SHALL process eoc and treat start per REQ-023.
REQ-029 On eoc coinciding with stop, SHALL capture C per REQ-026 and still pulse stop_cmd.
REQ-030 SHALL use no start/stop/clear_flags CTRL storage; these are write-strobe events only.

Reset
REQ-031 While rst=1, SHALL clear all registers (P/E/M/CONST/C/SPARE/busy/done/err) and drive start_cmd=stop_cmd=0, rsa_* = 0, spare=0.
REQ-032 On reset mid-operation (busy=1), SHALL drop busy immediately with no stop_cmd pulse; C retains the reset value 0.

Verification
REQ-033 Write P bytes 0x34@4, 0x12@5 and read back -> rsa_p=0x1234, reads 0x34 and 0x12; read of address 3 -> 0x00.
REQ-034 CTRL=0x01 -> start_cmd high exactly 1 cycle after the write edge, STATUS=0x01; write 0xFF@4 while busy -> rsa_p unchanged, STATUS=0x05.
REQ-035 Busy, rsa_c=0xBEEF, eoc held 3 cycles -> C reads 0xEF@12, 0xBE@13, STATUS=0x02; changing rsa_c afterwards leaves C unchanged.
REQ-036 Busy, CTRL=0x03 -> stop_cmd pulse, no start_cmd, STATUS=0x00; then CTRL=0x04 after err set -> STATUS bit2=0.
REQ-037 ena=0 with reg_wr and CTRL=0x01 -> no pulse, STATUS unchanged; rst asserted while busy -> all outputs 0 asynchronously.
